// File: rtl/mult_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mult_pkg
// Purpose  : Shared widths, iteration count and FSM encoding for the
//            shift-add sequential multiplier.
// Revision : 1.0
// ============================================================================
package mult_pkg;

   localparam int OP_W  = 8;
   localparam int RES_W = 16;
   localparam int ITERS = 8;
   localparam int CNT_W = 4;

   typedef enum logic [0:0] {
      IDLE        = 1'b0,
      MULTIPLYING = 1'b1
   } state_t;

endpackage : mult_pkg
`default_nettype wire

// File: rtl/sequential_multiplier.sv
`default_nettype none
// ============================================================================
// Module   : sequential_multiplier
// Purpose  : 8x8 unsigned shift-add multiplier, fixed 9-cycle latency.
//            Define MUL_OVERFLOW_EN to add the overflow output.
// Revision : 1.0
// ============================================================================
module sequential_multiplier
   import mult_pkg::*;
(
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [OP_W-1:0]  multiplicand,
   input  logic [OP_W-1:0]  multiplier,
   output logic [RES_W-1:0] product,
   output logic             done,
   output logic             busy
`ifdef MUL_OVERFLOW_EN
   ,
   output logic             overflow
`endif
);

   localparam logic [CNT_W-1:0] ITERS_CNT = CNT_W'(ITERS);

   state_t            r_state;
   state_t            w_next;
   logic              w_accept;
   logic              w_finish;

   logic [RES_W-1:0]  r_a;
   logic [OP_W-1:0]   r_b;
   logic [RES_W-1:0]  r_p;
   logic [CNT_W-1:0]  r_count;

   always_ff @(posedge clk) begin
      if (rst) r_state <= IDLE;
      else     r_state <= w_next;
   end

   always_comb begin
      w_next   = r_state;
      w_accept = 1'b0;
      w_finish = 1'b0;
      case (r_state)
         IDLE: begin
            if (start) begin
               w_accept = 1'b1;
               w_next   = MULTIPLYING;
            end
         end
         MULTIPLYING: begin
            // All eight iterations are done; this edge publishes the result.
            if (r_count == ITERS_CNT) begin
               w_finish = 1'b1;
               w_next   = IDLE;
            end
         end
         default: w_next = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_a     <= '0;
         r_b     <= '0;
         r_p     <= '0;
         r_count <= '0;
         product <= '0;
         done    <= 1'b0;
         busy    <= 1'b0;
`ifdef MUL_OVERFLOW_EN
         overflow <= 1'b0;
`endif
      end else begin
         done <= 1'b0;
         if (w_accept) begin
            r_a     <= {{(RES_W-OP_W){1'b0}}, multiplicand};
            r_b     <= multiplier;
            r_p     <= '0;
            r_count <= '0;
            busy    <= 1'b1;
         end else if (w_finish) begin
            product <= r_p;
            done    <= 1'b1;
            busy    <= 1'b0;
`ifdef MUL_OVERFLOW_EN
            overflow <= |r_p[RES_W-1:OP_W];
`endif
         end else if (r_state == MULTIPLYING) begin
            if (r_b[0]) r_p <= r_p + r_a;
            r_a     <= r_a << 1;
            r_b     <= r_b >> 1;
            r_count <= r_count + 1'b1;
         end
      end
   end

endmodule : sequential_multiplier
`default_nettype wire

// File: tb/tb_sequential_multiplier.sv
`default_nettype none
// ============================================================================
// Module   : tb_sequential_multiplier
// Purpose  : Scoreboard bench for sequential_multiplier (directed vectors).
// Revision : 1.0
// ============================================================================
module tb_sequential_multiplier;

   logic        clk;
   logic        rst;
   logic        start;
   logic [7:0]  multiplicand;
   logic [7:0]  multiplier;
   logic [15:0] product;
   logic        done;
   logic        busy;
`ifdef MUL_OVERFLOW_EN
   logic        overflow;
`endif

   sequential_multiplier dut (
      .clk          (clk),
      .rst          (rst),
      .start        (start),
      .multiplicand (multiplicand),
      .multiplier   (multiplier),
      .product      (product),
      .done         (done),
      .busy         (busy)
`ifdef MUL_OVERFLOW_EN
      ,
      .overflow     (overflow)
`endif
   );

   typedef struct {
      logic [15:0] prod;
      int          cyc;
   } exp_t;

   exp_t q[$];
   int   errors = 0;
   int   checks = 0;
   int   cyc    = 0;
   logic done_prev = 1'b0;

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial forever begin
      @(posedge clk);
      cyc++;
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Monitor: every done pulse pops the oldest expected result.
   initial forever begin
      exp_t e;
      @(negedge clk);
      if (done) begin
         if (q.size() == 0) begin
            chk("unexpected_done", 32'(done), 32'd0);
         end else begin
            e = q.pop_front();
            chk("product", 32'(product), 32'(e.prod));
            chk("latency_cycle", 32'(cyc), 32'(e.cyc));
`ifdef MUL_OVERFLOW_EN
            chk("overflow", 32'(overflow), 32'(e.prod[15:8] != 8'd0));
`endif
         end
         if (done_prev) chk("done_width", 32'(done_prev && done), 32'd0);
      end
      done_prev = done;
   end

   task automatic issue(input logic [7:0] a, input logic [7:0] b,
                        input logic [15:0] exp, input bit push);
      start        = 1'b1;
      multiplicand = a;
      multiplier   = b;
      @(posedge clk);
      #1;
      start = 1'b0;
      chk("busy_after_start", 32'(busy), 32'd1);
      if (push) q.push_back('{exp, cyc + 9});
   endtask

   task automatic run(input logic [7:0] a, input logic [7:0] b, input logic [15:0] exp);
      issue(a, b, exp, 1'b1);
      repeat (10) @(posedge clk);
      #1;
   endtask

   initial begin
      rst          = 1'b1;
      start        = 1'b0;
      multiplicand = 8'd0;
      multiplier   = 8'd0;
      repeat (2) @(posedge clk);
      #1;
      chk("reset_product", 32'(product), 32'd0);
      chk("reset_done", 32'(done), 32'd0);
      chk("reset_busy", 32'(busy), 32'd0);
`ifdef MUL_OVERFLOW_EN
      chk("reset_overflow", 32'(overflow), 32'd0);
`endif

      // Reset and start on the same edge: start must be dropped.
      start        = 1'b1;
      multiplicand = 8'd5;
      multiplier   = 8'd5;
      @(posedge clk);
      #1;
      rst   = 1'b0;
      start = 1'b0;
      chk("rst_wins_busy", 32'(busy), 32'd0);
      repeat (12) @(posedge clk);
      #1;
      chk("rst_wins_idle", 32'(busy), 32'd0);

      run(8'd13,  8'd11,  16'h008F);
      run(8'd255, 8'd255, 16'hFE01);
      run(8'd0,   8'd200, 16'h0000);
      run(8'd200, 8'd0,   16'h0000);

      // Start ignored mid-operation, then back-to-back start in the done cycle.
      issue(8'd16, 8'd16, 16'h0100, 1'b1);
      repeat (3) @(posedge clk);
      #1;
      start        = 1'b1;
      multiplicand = 8'd3;
      multiplier   = 8'd3;
      @(posedge clk);
      #1;
      start = 1'b0;
      chk("busy_during_op", 32'(busy), 32'd1);
      repeat (5) @(posedge clk);
      #1;
      chk("done_at_e9", 32'(done), 32'd1);
      issue(8'd3, 8'd3, 16'h0009, 1'b1);
      repeat (9) @(posedge clk);
      #1;
      repeat (5) @(posedge clk);
      #1;
      chk("product_held", 32'(product), 32'h0009);
      chk("done_cleared", 32'(done), 32'd0);

      // Abort mid-operation with reset.
      issue(8'd7, 8'd9, 16'h003F, 1'b0);
      repeat (4) @(posedge clk);
      #1;
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      chk("abort_busy", 32'(busy), 32'd0);
      chk("abort_product", 32'(product), 32'd0);
      chk("abort_done", 32'(done), 32'd0);
      repeat (12) @(posedge clk);
      #1;
      chk("abort_still_idle", 32'(busy), 32'd0);
      chk("abort_product_hold", 32'(product), 32'd0);

      run(8'd2, 8'd5, 16'h000A);

      repeat (3) @(posedge clk);
      #1;
      chk("scoreboard_drained", 32'(q.size()), 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule : tb_sequential_multiplier
`default_nettype wire
